// File: rtl/alu_seq_if.sv
// alu_seq_if: instruction handshake, datapath controls and status of the ALU sequencer.
//   master : instruction source, drives in_valid/instr, observes everything else
//   slave  : the sequencer, drives in_ready, datapath controls, done, err, instr_count
interface alu_seq_if;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned CNT_W   = 16;

  logic               in_valid;
  logic [INSTR_W-1:0] instr;
  logic               in_ready;
  logic [2:0]         nsel;
  logic               vsel;
  logic               write;
  logic               loada;
  logic               loadb;
  logic               loadc;
  logic               loads;
  logic               asel;
  logic               bsel;
  logic [1:0]         alu_op;
  logic [1:0]         shift;
  logic               done;
  logic               err;
  logic [CNT_W-1:0]   instr_count;

  modport master (
    output in_valid, instr,
    input  in_ready, nsel, vsel, write, loada, loadb, loadc, loads,
           asel, bsel, alu_op, shift, done, err, instr_count
  );

  modport slave (
    input  in_valid, instr,
    output in_ready, nsel, vsel, write, loada, loadb, loadc, loads,
           asel, bsel, alu_op, shift, done, err, instr_count
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller sequencing register-file / ALU strobes for a
// small instruction set (MOV imm, MOV reg, ADD, CMP, AND, MVN).
// Ports:
//   clk    : clock, all state on rising edge
//   reset  : synchronous active-high reset
//   bus    : alu_seq_if.slave (instruction handshake, datapath controls, status)
// Optional feature: define ALU_SEQ_PERF_CNT_EN to enable the retired-instruction
// counter on bus.instr_count; otherwise it reads constant zero.
module alu_sequencer (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_LOAD_A    = 3'd2,
    S_LOAD_B    = 3'd3,
    S_EXEC      = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               err_q, err_d;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [1:0] sh;
  logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;
  logic       accept_c;

  // Instruction field decode from the held IR
  assign opcode     = ir_q[15:13];
  assign op         = ir_q[12:11];
  assign sh         = ir_q[4:3];
  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_cmp     = is_alu && (op == 2'b01);
  assign is_mvn     = is_alu && (op == 2'b11);
  assign accept_c   = (state_q == S_WAIT) && bus.in_valid;

  // Register operand fields are consumed by the datapath, not by the sequencer
  logic unused_fields;
  assign unused_fields = ^{ir_q[10:5], ir_q[2:0]};

  // State, IR and error flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  // Next-state, IR capture and error flag update
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    err_d   = err_q;
    case (state_q)
      S_WAIT: begin
        if (bus.in_valid) begin
          ir_d    = bus.instr;
          err_d   = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_mov_imm)                state_d = S_WRITE_IMM;
        else if (is_mov_reg || is_mvn) state_d = S_LOAD_B;
        else if (is_alu)               state_d = S_LOAD_A;
        else begin
          state_d = S_WAIT;
          err_d   = 1'b1;
        end
      end
      S_LOAD_A:    state_d = S_LOAD_B;
      S_LOAD_B:    state_d = S_EXEC;
      S_EXEC:      state_d = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
      S_WRITE_IMM: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  logic       in_ready_c, vsel_c, write_c, loada_c, loadb_c, loadc_c, loads_c;
  logic       asel_c, bsel_c, done_c;
  logic [2:0] nsel_c;
  logic [1:0] alu_op_c, shift_c;

  // Moore control decode from state and IR
  always_comb begin
    in_ready_c = 1'b0;
    nsel_c     = 3'b000;
    vsel_c     = 1'b0;
    write_c    = 1'b0;
    loada_c    = 1'b0;
    loadb_c    = 1'b0;
    loadc_c    = 1'b0;
    loads_c    = 1'b0;
    asel_c     = 1'b0;
    bsel_c     = 1'b0;
    alu_op_c   = 2'b00;
    shift_c    = 2'b00;
    done_c     = 1'b0;
    case (state_q)
      S_WAIT:   in_ready_c = 1'b1;
      S_LOAD_A: begin
        nsel_c  = 3'b001;
        loada_c = 1'b1;
      end
      S_LOAD_B: begin
        nsel_c  = 3'b100;
        loadb_c = 1'b1;
      end
      S_EXEC: begin
        loadc_c  = 1'b1;
        shift_c  = sh;
        // MOV reg passes B through an add with A forced to zero
        asel_c   = is_mov_reg;
        alu_op_c = is_mov_reg ? 2'b00 : op;
        loads_c  = is_cmp;
        done_c   = is_cmp;
      end
      S_WRITE_REG: begin
        nsel_c  = 3'b010;
        write_c = 1'b1;
        done_c  = 1'b1;
      end
      S_WRITE_IMM: begin
        nsel_c  = 3'b001;
        vsel_c  = 1'b1;
        write_c = 1'b1;
        done_c  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.in_ready = in_ready_c;
  assign bus.nsel     = nsel_c;
  assign bus.vsel     = vsel_c;
  assign bus.write    = write_c;
  assign bus.loada    = loada_c;
  assign bus.loadb    = loadb_c;
  assign bus.loadc    = loadc_c;
  assign bus.loads    = loads_c;
  assign bus.asel     = asel_c;
  assign bus.bsel     = bsel_c;
  assign bus.alu_op   = alu_op_c;
  assign bus.shift    = shift_c;
  assign bus.done     = done_c;
  assign bus.err      = err_q;

`ifdef ALU_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset)       cnt_q <= '0;
    else if (done_c) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.instr_count = cnt_q;
`else
  assign bus.instr_count = CNT_W'(0);
`endif

  logic unused_accept;
  assign unused_accept = accept_c;
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: in_valid  in  1  instruction offered; instr  in  16  instruction word; in_ready  out  1  sequencer idle, accepts instr.
REQ-004 SHALL have datapath controls, all out: nsel 3 (one-hot regfile select: 001=Rn, 010=Rd, 100=Rm); vsel 1 (writeback source: 0=ALU result C, 1=sign-extended imm8); write 1; loada 1; loadb 1; loadc 1; loads 1; asel 1 (1 forces ALU A input to 0); bsel 1; alu_op 2 (00 add, 01 subtract, 10 and, 11 invert B); shift 2.
REQ-005 SHALL have status: done  out  1  final-cycle strobe; err  out  1  illegal instruction flag; instr_count  out  16  retired-instruction count.

Function
REQ-006 Instruction fields SHALL be: opcode=[15:13], op=[12:11], Rn=[10:8], Rd=[7:5], sh=[4:3], Rm=[2:0], imm8=[7:0].
REQ-007 Legal set SHALL be: 110/10 MOV Rn,#imm8; 110/00 MOV Rd,Rm; 101/00 ADD; 101/01 CMP; 101/10 AND; 101/11 MVN; all other opcode/op illegal.
REQ-008 States SHALL be WAIT, DECODE, LOAD_A, LOAD_B, EXEC, WRITE_REG, WRITE_IMM; all outputs Moore (decoded from state and internal IR only).
REQ-009 WAIT: in_ready=1; on in_valid=1 at clock edge, IR<=instr, err<=0, next DECODE; else stay.
REQ-010 DECODE: all strobes 0; next WRITE_IMM (MOV imm), LOAD_B (MOV reg, MVN), LOAD_A (ADD/CMP/AND), WAIT with err<=1 (illegal).
REQ-011 LOAD_A: nsel=001, loada=1, next LOAD_B.
REQ-012 LOAD_B: nsel=100, loadb=1, next EXEC.
REQ-013 EXEC: loadc=1, shift=sh, bsel=0; MOV reg: asel=1, alu_op=00; 101 class: asel=0, alu_op=op; loads=1 only for CMP; next WAIT with done=1 for CMP, else WRITE_REG.
REQ-014 WRITE_REG: nsel=010, vsel=0, write=1, done=1, next WAIT.
REQ-015 WRITE_IMM: nsel=001, vsel=1, write=1, done=1, next WAIT.
REQ-016 Any control not named for a state SHALL be 0 in that state; write, loada, loadb, loadc, loads SHALL each be high for at most one cycle per instruction.
REQ-017 Latency from accept edge: MOV imm 2 cycles, MOV reg/MVN 4, CMP 4, ADD/AND 5; in_ready reasserts the cycle after done.
REQ-018 in_valid/instr outside WAIT SHALL be ignored and not latched.
REQ-019 err SHALL hold until next accepted instruction or reset; illegal instructions SHALL assert no datapath strobe.

Reset
REQ-020 reset=1 at an edge SHALL force WAIT, IR=0, err=0, instr_count=0, from any state including mid-instruction; aborted instruction SHALL not write or retire.
REQ-021 In cycle after reset: in_ready=1, all strobes, done, nsel, vsel, asel, bsel, alu_op, shift = 0.

Configuration
REQ-022 Macro ALU_SEQ_PERF_CNT_EN defined: instr_count increments by 1 on each cycle done=1, wrapping 0xFFFF->0x0000; illegal instructions not counted.
REQ-023 Macro undefined: instr_count port present, tied to 16'h0000, no counter register.

Verification
REQ-024 instr=0xD325 accepted -> next cycle DECODE, following cycle nsel=001, vsel=1, write=1, done=1; then in_ready=1.
REQ-025 instr=0xA140 (ADD R2,R1,R0) -> loada(nsel=001), loadb(nsel=100), loadc with alu_op=00/asel=0/loads=0, write(nsel=010, vsel=0) on consecutive cycles 2-5.
REQ-026 instr=0xA900 (CMP R1,R0) -> EXEC has alu_op=01, loadc=1, loads=1, done=1; write never asserted.
REQ-027 instr=0xB88D (MVN R4,R5, sh=01) -> no loada; LOAD_B nsel=100; EXEC alu_op=11, shift=01; WRITE_REG nsel=010.
REQ-028 instr=0x0000 -> err=1 two cycles after accept, no strobes, in_ready=1; next legal accept clears err.
REQ-029 reset pulsed during LOAD_B of 0xA140 -> WAIT next cycle, write never asserted, instr_count=0; with ALU_SEQ_PERF_CNT_EN, 3 legal instructions then read instr_count=3.
